stopwatch_ctrl: RTL and testbench

- Sequencing controller for the BCD timekeeping chain: one mod-100 centisecond counter, one mod-60 seconds counter and one mod-60 minutes counter. Each counter is 8-bit packed BCD, with an active-low clear and a count enable.
- Turns two debounced button pulses into counter enables and clears.
- Generates the 100 Hz count tick from the system clock.
- Holds a lap (split) snapshot, saturates at 59:59.99, and selects the time shown on the display.

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/tick_gen.sv | 34 +++
 rtl/stopwatch_ctrl.sv | 113 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared state encodings and BCD limits for the stopwatch sequencing logic.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    LAP  = 3'd2,
    STOP = 3'd3,
    FULL = 3'd4
  } state_t;

  localparam logic [7:0]  CS_MAX   = 8'h99;
  localparam logic [7:0]  SEC_MAX  = 8'h59;
  localparam logic [7:0]  MIN_MAX  = 8'h59;
  localparam logic [23:0] TIME_MAX = 24'h595999;

  function automatic logic is_running(state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Centisecond prescaler: counts while running, holds otherwise, zeroed on request.
module tick_gen #(
  parameter int DIV = 500000,
  parameter int PW  = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic zero,
  output logic tick
);

  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (zero)
      cnt_d = '0;
    else if (run)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button FSM, counter enables/clear, lap snapshot and display select.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIV = 500000,
  parameter int PW  = 19
) (
  input  logic        CP,
  input  logic        nCR,
  input  logic        btn_ss,
  input  logic        btn_lap,
  input  logic [7:0]  cs_cnt,
  input  logic [7:0]  sec_cnt,
  input  logic [7:0]  min_cnt,
  output logic        cs_en,
  output logic        sec_en,
  output logic        min_en,
  output logic        cnt_nclr,
  output logic [23:0] disp,
  output logic [2:0]  state,
  output logic        ovf
);

  state_t      state_q, state_d;
  logic        cnt_nclr_q, cnt_nclr_d;
  logic        ovf_q, ovf_d;
  logic [23:0] lap_q, lap_d;
  logic [23:0] live;
  logic        at_max;
  logic        running;
  logic        tick;

  assign live    = {min_cnt, sec_cnt, cs_cnt};
  assign at_max  = (live == TIME_MAX);
  assign running = is_running(state_q);

  tick_gen #(
    .DIV (DIV),
    .PW  (PW)
  ) u_tick_gen (
    .clk   (CP),
    .rst_n (nCR),
    .run   (running),
    .zero  ((state_q == IDLE) || (state_q == FULL)),
    .tick  (tick)
  );

  // A tick at 59:59.99 is swallowed so the counters never roll over.
  assign cs_en  = tick && !at_max;
  assign sec_en = cs_en && (cs_cnt == CS_MAX);
  assign min_en = sec_en && (sec_cnt == SEC_MAX);

  always_comb begin
    state_d    = state_q;
    lap_d      = lap_q;
    cnt_nclr_d = 1'b1;
    if (tick && at_max) begin
      state_d = FULL;
    end else begin
      case (state_q)
        IDLE: if (btn_ss) state_d = RUN;
        RUN: begin
          if (btn_ss) begin
            state_d = STOP;
          end else if (btn_lap) begin
            state_d = LAP;
            lap_d   = live;
          end
        end
        LAP: begin
          if (btn_ss)       state_d = STOP;
          else if (btn_lap) state_d = RUN;
        end
        STOP: begin
          if (btn_ss) begin
            state_d = RUN;
          end else if (btn_lap) begin
            state_d    = IDLE;
            cnt_nclr_d = 1'b0;
          end
        end
        FULL: begin
          if (btn_lap) begin
            state_d    = IDLE;
            cnt_nclr_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    ovf_d = (state_d == FULL);
  end

  always_ff @(posedge CP) begin
    if (!nCR) begin
      state_q    <= IDLE;
      cnt_nclr_q <= 1'b0;
      ovf_q      <= 1'b0;
      lap_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_nclr_q <= cnt_nclr_d;
      ovf_q      <= ovf_d;
      lap_q      <= lap_d;
    end
  end

  assign cnt_nclr = cnt_nclr_q;
  assign ovf      = ovf_q;
  assign state    = state_q;
  assign disp     = (state_q == LAP) ? lap_q : live;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DIV=4 driving a behavioural BCD counter chain.
module tb_stopwatch_ctrl;

  localparam int DIV    = 4;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_LAP  = 2;
  localparam int S_STOP = 3;
  localparam int S_FULL = 4;
  localparam int T_MAX  = 359999;

  logic        CP = 1'b0;
  logic        nCR = 1'b0;
  logic        btn_ss = 1'b0;
  logic        btn_lap = 1'b0;
  logic [7:0]  cs_cnt, sec_cnt, min_cnt;
  logic        cs_en, sec_en, min_en, cnt_nclr, ovf;
  logic [23:0] disp;
  logic [2:0]  st;

  int cs_v = 0, sec_v = 0, min_v = 0;
  int pl_cs = 0, pl_sec = 0, pl_min = 0;
  bit pl_req = 1'b0;
  bit chk_on = 1'b0;
  int n_checks = 0;
  int n_errs = 0;

  typedef struct {
    int          st;
    int          pre;
    logic [23:0] lap;
    bit          nclr;
    bit          ovf;
  } model_t;

  model_t m = '{S_IDLE, 0, 24'h0, 1'b0, 1'b0};

  typedef struct {
    bit ss;
    bit lap;
    int wait_c;
    int exp_state;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [7:0] to_bcd8(int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  assign cs_cnt  = to_bcd8(cs_v);
  assign sec_cnt = to_bcd8(sec_v);
  assign min_cnt = to_bcd8(min_v);

  logic [23:0] live;
  assign live = {min_cnt, sec_cnt, cs_cnt};

  stopwatch_ctrl #(
    .DIV (DIV),
    .PW  (3)
  ) dut (
    .CP       (CP),
    .nCR      (nCR),
    .btn_ss   (btn_ss),
    .btn_lap  (btn_lap),
    .cs_cnt   (cs_cnt),
    .sec_cnt  (sec_cnt),
    .min_cnt  (min_cnt),
    .cs_en    (cs_en),
    .sec_en   (sec_en),
    .min_en   (min_en),
    .cnt_nclr (cnt_nclr),
    .disp     (disp),
    .state    (st),
    .ovf      (ovf)
  );

  always #5 CP = ~CP;

  // Counter chain: each counter wraps independently on its own enable.
  always @(posedge CP) begin
    if (cnt_nclr === 1'b0) begin
      cs_v <= 0; sec_v <= 0; min_v <= 0;
    end else if (pl_req) begin
      cs_v <= pl_cs; sec_v <= pl_sec; min_v <= pl_min;
    end else begin
      if (cs_en === 1'b1)  cs_v  <= (cs_v + 1) % 100;
      if (sec_en === 1'b1) sec_v <= (sec_v + 1) % 60;
      if (min_en === 1'b1) min_v <= (min_v + 1) % 60;
    end
  end

  function automatic model_t model_step(model_t c, bit ss, bit lp, int tot, logic [23:0] lv);
    model_t n = c;
    bit     run_s = (c.st == S_RUN) || (c.st == S_LAP);
    n.nclr = 1'b1;
    if (run_s && c.pre == DIV - 1 && tot == T_MAX) begin
      n.st = S_FULL;
    end else begin
      case (c.st)
        S_IDLE: if (ss) n.st = S_RUN;
        S_RUN:  if (ss) n.st = S_STOP; else if (lp) begin n.st = S_LAP; n.lap = lv; end
        S_LAP:  if (ss) n.st = S_STOP; else if (lp) n.st = S_RUN;
        S_STOP: if (ss) n.st = S_RUN;  else if (lp) begin n.st = S_IDLE; n.nclr = 1'b0; end
        S_FULL: if (lp) begin n.st = S_IDLE; n.nclr = 1'b0; end
        default: n.st = S_IDLE;
      endcase
    end
    if (c.st == S_IDLE || c.st == S_FULL) n.pre = 0;
    else if (run_s)                        n.pre = (c.pre + 1) % DIV;
    n.ovf = (n.st == S_FULL);
    return n;
  endfunction

  always @(posedge CP) begin
    if (!nCR)
      m <= '{S_IDLE, 0, 24'h0, 1'b0, 1'b0};
    else
      m <= model_step(m, btn_ss, btn_lap, min_v * 6000 + sec_v * 100 + cs_v, live);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      if (n_errs <= 40)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_check();
    int tot;
    bit tk, e_cs, e_sec, e_min;
    tot   = min_v * 6000 + sec_v * 100 + cs_v;
    tk    = ((m.st == S_RUN) || (m.st == S_LAP)) && (m.pre == DIV - 1);
    e_cs  = tk && (tot != T_MAX);
    e_sec = e_cs && (tot % 100 == 99);
    e_min = e_sec && (tot % 6000 == 5999);
    chk("model_state", 32'(st), 32'(m.st));
    chk("model_ovf", 32'(ovf), 32'(m.ovf));
    chk("model_nclr", 32'(cnt_nclr), 32'(m.nclr));
    chk("model_disp", 32'(disp), 32'((m.st == S_LAP) ? m.lap : live));
    chk("model_cs_en", 32'(cs_en), 32'(e_cs));
    chk("model_sec_en", 32'(sec_en), 32'(e_sec));
    chk("model_min_en", 32'(min_en), 32'(e_min));
  endtask

  task automatic step();
    @(negedge CP);
    if (chk_on) model_check();
  endtask

  task automatic press(input bit ss, input bit lp);
    btn_ss  = ss;
    btn_lap = lp;
    step();
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
  endtask

  task automatic preload(input int mi, input int se, input int c);
    pl_min = mi; pl_sec = se; pl_cs = c;
    pl_req = 1'b1;
    step();
    pl_req = 1'b0;
  endtask

  task automatic do_reset();
    btn_ss = 1'b0; btn_lap = 1'b0;
    nCR = 1'b0;
    step();
    step();
    nCR = 1'b1;
    step();
  endtask

  task automatic wait_disp(input string name, input logic [23:0] target, input int max_c);
    int n = 0;
    while (disp !== target && n < max_c) begin step(); n++; end
    chk(name, 32'(disp), 32'(target));
  endtask

  task automatic wait_cs_en(input string name, input int max_c);
    int n = 0;
    while (cs_en !== 1'b1 && n < max_c) begin step(); n++; end
    chk(name, 32'(cs_en), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int r;
    logic [23:0] snap;
    bit en_seen;

    tbl[0]  = '{1'b0, 1'b1, 5, S_IDLE};
    tbl[1]  = '{1'b1, 1'b0, 5, S_RUN};
    tbl[2]  = '{1'b0, 1'b1, 5, S_LAP};
    tbl[3]  = '{1'b0, 1'b1, 5, S_RUN};
    tbl[4]  = '{1'b1, 1'b0, 5, S_STOP};
    tbl[5]  = '{1'b1, 1'b0, 5, S_RUN};
    tbl[6]  = '{1'b0, 1'b1, 5, S_LAP};
    tbl[7]  = '{1'b1, 1'b0, 5, S_STOP};
    tbl[8]  = '{1'b1, 1'b0, 5, S_RUN};
    tbl[9]  = '{1'b1, 1'b1, 5, S_STOP};
    tbl[10] = '{1'b0, 1'b1, 5, S_IDLE};
    tbl[11] = '{1'b1, 1'b1, 5, S_RUN};
    tbl[12] = '{1'b1, 1'b0, 5, S_STOP};
    tbl[13] = '{1'b0, 1'b1, 5, S_IDLE};

    chk_on = 1'b1;
    nCR = 1'b0;
    step();
    chk("reset_state", 32'(st), S_IDLE);
    chk("reset_nclr", 32'(cnt_nclr), 0);
    chk("reset_ovf", 32'(ovf), 0);
    step();
    nCR = 1'b1;
    step();
    chk("reset_release_nclr", 32'(cnt_nclr), 1);
    chk("reset_disp", 32'(disp), 0);

    for (int i = 0; i < 14; i++) begin
      press(tbl[i].ss, tbl[i].lap);
      chk("tbl_state", 32'(st), 32'(tbl[i].exp_state));
      repeat (tbl[i].wait_c) step();
    end

    // First tick latency and 400-cycle count.
    do_reset();
    press(1'b1, 1'b0);
    k = 1;
    while (cs_en !== 1'b1 && k < 20) begin step(); k++; end
    chk("first_tick_latency", 32'(k), 4);
    repeat (401 - k) step();
    chk("disp_after_400", 32'(disp), 24'h000100);

    // Carry into seconds, then into minutes.
    do_reset();
    preload(0, 0, 90);
    press(1'b1, 1'b0);
    wait_disp("reach_000099", 24'h000099, 100);
    wait_cs_en("tick_at_99", 10);
    chk("sec_en_at_99", 32'(sec_en), 1);
    chk("min_en_at_99", 32'(min_en), 0);
    step();
    chk("disp_000100", 32'(disp), 24'h000100);
    press(1'b1, 1'b0);
    preload(0, 59, 95);
    press(1'b1, 1'b0);
    wait_disp("reach_005999", 24'h005999, 60);
    wait_cs_en("tick_at_5999", 10);
    chk("min_en_at_5999", 32'(min_en), 1);
    step();
    chk("disp_010000", 32'(disp), 24'h010000);

    // Lap freeze and release.
    do_reset();
    preload(0, 12, 20);
    press(1'b1, 1'b0);
    wait_disp("reach_001234", 24'h001234, 100);
    press(1'b0, 1'b1);
    chk("lap_state", 32'(st), S_LAP);
    repeat (20) step();
    chk("lap_frozen", 32'(disp), 24'h001234);
    chk("lap_live_moves", 32'(live != 24'h001234), 1);
    press(1'b0, 1'b1);
    chk("lap_release_state", 32'(st), S_RUN);
    chk("lap_release_disp", 32'(disp), 32'(live));

    // Stop with prescaler held at 2, resume.
    k = 0;
    while (m.pre != 1 && k < 10) begin step(); k++; end
    press(1'b1, 1'b0);
    chk("stop_state", 32'(st), S_STOP);
    snap = live;
    en_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (cs_en === 1'b1) en_seen = 1'b1;
    end
    chk("stop_no_enable", 32'(en_seen), 0);
    chk("stop_counts_held", 32'(live), 32'(snap));
    press(1'b1, 1'b0);
    k = 1;
    while (cs_en !== 1'b1 && k < 10) begin step(); k++; end
    chk("resume_latency", 32'(k), 2);

    // Saturation at 59:59.99.
    press(1'b1, 1'b0);
    preload(59, 59, 97);
    press(1'b1, 1'b0);
    wait_disp("reach_max", 24'h595999, 40);
    k = 0;
    while (st !== 3'(S_FULL) && k < 10) begin step(); k++; end
    chk("full_state", 32'(st), S_FULL);
    chk("full_ovf", 32'(ovf), 1);
    chk("full_disp", 32'(disp), 24'h595999);
    press(1'b1, 1'b0);
    chk("full_ss_ignored", 32'(st), S_FULL);
    press(1'b0, 1'b1);
    chk("full_exit_state", 32'(st), S_IDLE);
    chk("full_exit_nclr", 32'(cnt_nclr), 0);
    step();
    chk("full_exit_nclr_back", 32'(cnt_nclr), 1);
    chk("full_exit_disp", 32'(disp), 0);

    // Simultaneous buttons in RUN, then reset mid-run.
    press(1'b1, 1'b0);
    repeat (10) step();
    press(1'b1, 1'b1);
    chk("both_btn_state", 32'(st), S_STOP);
    chk("both_btn_disp_live", 32'(disp), 32'(live));
    press(1'b1, 1'b0);
    repeat (7) step();
    nCR = 1'b0;
    step();
    chk("midrun_reset_state", 32'(st), S_IDLE);
    chk("midrun_reset_nclr", 32'(cnt_nclr), 0);
    nCR = 1'b1;
    step();
    chk("midrun_reset_disp", 32'(disp), 0);
    chk("midrun_reset_nclr_back", 32'(cnt_nclr), 1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 199));
      if (r < 6)       press(1'b1, 1'b0);
      else if (r < 12) press(1'b0, 1'b1);
      else if (r < 14) press(1'b1, 1'b1);
      else if (r < 16) preload(59, 59, int'($urandom_range(80, 99)));
      else if (r == 16) preload(int'($urandom_range(0, 59)), int'($urandom_range(0, 59)),
                                int'($urandom_range(0, 99)));
      else if (r == 17) do_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
